// File: rtl/first_layer_merge.sv
// Three-channel 3x3 stride-2 convolution with channel merge, 2-stage product/sum pipeline.
// Define RELU_EN to clamp negative saturated results to zero before they reach pxl_out.
module first_layer_merge #(
   parameter int               D          = 9,
   parameter int               data_width = 32,
   parameter logic [27*8-1:0]  KERNEL     = {27{8'h01}}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in_1,
   input  logic                         valid_in_2,
   input  logic                         valid_in_3,
   input  logic signed [data_width-1:0] pxl_in_1,
   input  logic signed [data_width-1:0] pxl_in_2,
   input  logic signed [data_width-1:0] pxl_in_3,
   output logic signed [data_width-1:0] pxl_out,
   output logic                         valid_out
);

   localparam int             CW   = (D > 1) ? $clog2(D) : 1;
   localparam int             PW   = data_width + 8;
   localparam int             AW   = data_width + 13;
   localparam logic [CW-1:0]  LAST = CW'(D - 1);

   logic [CW-1:0] col_q, col_d, row_q, row_d;
   logic          accept, emit;
   logic          vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, valid_out_q, valid_out_d;

   logic signed [data_width-1:0] pix      [3];
   logic signed [data_width-1:0] lb_top_q [3][D];
   logic signed [data_width-1:0] lb_mid_q [3][D];
   logic signed [data_width-1:0] win_q    [3][3][3];
   logic signed [data_width-1:0] win_d    [3][3][3];
   logic signed [PW-1:0]         prod_q   [27];
   logic signed [PW-1:0]         prod_d   [27];
   logic signed [AW-1:0]         sum_d;
   logic signed [data_width-1:0] pxl_q, pxl_d;

   function automatic logic signed [PW-1:0] mul(input logic signed [data_width-1:0] a,
                                                input logic signed [7:0]            w);
      logic signed [PW-1:0] ax, wx;
      ax = PW'(a);
      wx = PW'(w);
      return ax * wx;
   endfunction

   // The result fits when all bits above the output sign bit agree with it.
   function automatic logic signed [data_width-1:0] saturate(input logic signed [AW-1:0] a);
      if ((&a[AW-1:data_width-1]) || (~|a[AW-1:data_width-1]))
         return a[data_width-1:0];
      else if (a[AW-1])
         return {1'b1, {(data_width-1){1'b0}}};
      else
         return {1'b0, {(data_width-1){1'b1}}};
   endfunction

   function automatic logic signed [data_width-1:0] relu(input logic signed [data_width-1:0] a);
`ifdef RELU_EN
      return a[data_width-1] ? '0 : a;
`else
      return a;
`endif
   endfunction

   assign pix[0] = pxl_in_1;
   assign pix[1] = pxl_in_2;
   assign pix[2] = pxl_in_3;

   // Row-2 and col-2 even reduce to row and col even.
   always_comb begin
      accept = valid_in_1 & valid_in_2 & valid_in_3;
      emit   = accept && (row_q >= CW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
      col_d  = col_q;
      row_d  = row_q;
      if (accept) begin
         if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      vld_p0_d    = emit;
      vld_p1_d    = vld_p0_q;
      valid_out_d = vld_p1_q;
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 3; r++) begin
               win_d[ch][r][0] = win_q[ch][r][1];
               win_d[ch][r][1] = win_q[ch][r][2];
            end
            win_d[ch][0][2] = lb_top_q[ch][col_q];
            win_d[ch][1][2] = lb_mid_q[ch][col_q];
            win_d[ch][2][2] = pix[ch];
         end
      end
   end

   // Stage 1: 27 products from the completed window.
   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
               prod_d[ch*9 + kr*3 + kc] = mul(win_q[ch][kr][kc],
                                              KERNEL[(ch*9 + kr*3 + kc)*8 +: 8]);
            end
         end
      end
   end

   // Stage 2: merge, saturate, optional clamp; pxl_out holds between results.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < 27; i++)
         sum_d = sum_d + AW'(prod_q[i]);
      pxl_d = vld_p1_q ? relu(saturate(sum_d)) : pxl_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         vld_p0_q    <= 1'b0;
         vld_p1_q    <= 1'b0;
         valid_out_q <= 1'b0;
         pxl_q       <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         vld_p0_q    <= vld_p0_d;
         vld_p1_q    <= vld_p1_d;
         valid_out_q <= valid_out_d;
         pxl_q       <= pxl_d;
      end
   end

   always_ff @(posedge clk) begin
      win_q  <= win_d;
      prod_q <= prod_d;
      if (accept) begin
         for (int ch = 0; ch < 3; ch++) begin
            lb_top_q[ch][col_q] <= lb_mid_q[ch][col_q];
            lb_mid_q[ch][col_q] <= pix[ch];
         end
      end
   end

   assign pxl_out   = pxl_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_first_layer_merge.sv
// Directed bench for first_layer_merge (D=9, 32-bit): values, latency, hold, stall, saturation, reset.
module tb_first_layer_merge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
   logic [31:0] p1 = '0, p2 = '0, p3 = '0;
   logic [31:0] pxl_out;
   logic        valid_out;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          tr      = 0;
   int          tc      = 0;
   logic [31:0] exp_q[$];
   int          cyc_q[$];
   logic [31:0] last_pxl = '0;

   always #5 clk = ~clk;

   first_layer_merge #(9, 32) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in_1(v1),
      .valid_in_2(v2),
      .valid_in_3(v3),
      .pxl_in_1  (p1),
      .pxl_in_2  (p2),
      .pxl_in_3  (p3),
      .pxl_out   (pxl_out),
      .valid_out (valid_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: every cycle is either a reset cycle, an expected pulse, or a hold cycle.
   always @(posedge clk) begin
      logic [31:0] e;
      int          c;
      cyc = cyc + 1;
      #1;
      if (reset) begin
         chk("rst_valid", {31'b0, valid_out}, 32'd0);
         chk("rst_pxl", pxl_out, 32'd0);
         last_pxl = '0;
      end else if (valid_out) begin
         if (exp_q.size() == 0) begin
            chk("extra_pulse", {31'b0, valid_out}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("value", pxl_out, e);
            chk("latency", cyc, c);
            last_pxl = e;
         end
      end else begin
         chk("hold", pxl_out, last_pxl);
      end
   end

   task automatic drive(input logic [2:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
      @(negedge clk);
      {v1, v2, v3} = v;
      p1 = a;
      p2 = b;
      p3 = c;
   endtask

   // One accepted pixel; an emitting position expects its pulse 2 edges after acceptance.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] e, input bit keep);
      drive(3'b111, a, b, c);
      if (keep && tr >= 2 && tc >= 2 && (tr % 2 == 0) && (tc % 2 == 0)) begin
         exp_q.push_back(e);
         cyc_q.push_back(cyc + 3);
      end
      if (tc == 8) begin
         tc = 0;
         tr = (tr == 8) ? 0 : tr + 1;
      end else begin
         tc = tc + 1;
      end
   endtask

   // kind 0: constant on all channels; kind 1: ramp row*9+col on channel 1 only.
   task automatic frame(input int kind, input logic [31:0] val, input logic [31:0] e,
                        input int stall_at, input int npix);
      for (int i = 0; i < npix; i++) begin
         if (i == stall_at)
            repeat (5) drive(3'b101, $urandom, $urandom, $urandom);
         if (kind == 1)
            send(32'(tr*9 + tc), 32'd0, 32'd0, 32'(90 + 81*(tr-2) + 9*(tc-2)), 1'b1);
         else
            send(val, val, val, e, !(npix < 81 && i >= npix - 2));
      end
   endtask

   task automatic drain();
      repeat (4) drive(3'b000, 32'd0, 32'd0, 32'd0);
      chk("pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      cyc_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      {v1, v2, v3} = 3'b000;
      @(negedge clk);
      reset = 1'b0;
      tr = 0;
      tc = 0;
   endtask

   initial begin
      logic [31:0] neg_exp, min_exp;
`ifdef RELU_EN
      neg_exp = 32'd0;
      min_exp = 32'd0;
`else
      neg_exp = 32'hFFFF_FFE5;
      min_exp = 32'h8000_0000;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b0;

      frame(0, 32'd1, 32'd27, -1, 81);
      frame(1, 32'd0, 32'd0, -1, 81);
      drain();
      frame(1, 32'd0, 32'd0, 30, 81);
      drain();
      frame(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, 81);
      frame(0, 32'h8000_0000, min_exp, -1, 81);
      frame(0, 32'hFFFF_FFFF, neg_exp, -1, 81);
      drain();

      frame(0, 32'd1, 32'd27, -1, 40);
      do_reset();
      frame(0, 32'd1, 32'd27, -1, 81);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/first_layer_merge.md
Name: first_layer_merge

Overview:
- First convolution stage of the CNN front end: three pixel streams (R, G, B) of a D x D frame in raster order are convolved with a 3x3 kernel at stride 2, padding 0.
- The three per-channel results are summed ("merged") into one output channel.
- Output frame is ((D-3)/2+1) x ((D-3)/2+1). D=9 gives 4x4; D=299 gives 149x149 per kernel.
- One instance computes one output feature map; 32 instances form the 32-channel layer.

Parameters:
- D, 9, frame width and height in pixels (odd, >=3). Positional parameter #1.
- data_width, 32, pixel and result width; signed two's complement integer. Positional parameter #2.
- KERNEL, all 27 weights = 8'sd1, packed 27x8-bit signed weights. Index ch*9 + kr*3 + kc; ch 0..2 = channels 1..3; kr/kc 0 = top/left.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in_1  in  1  channel-1 pixel valid.
- valid_in_2  in  1  channel-2 pixel valid.
- valid_in_3  in  1  channel-3 pixel valid.
- pxl_in_1  in  data_width  channel-1 (red) pixel.
- pxl_in_2  in  data_width  channel-2 (green) pixel.
- pxl_in_3  in  data_width  channel-3 (blue) pixel.
- pxl_out  out  data_width  merged convolution result.
- valid_out  out  1  pxl_out holds a new result this cycle.

Behaviour:
- Interface fact: one clock (clk); reset is synchronous and active-high (reset).
- Pixel acceptance:
  - A pixel is accepted only when valid_in_1 & valid_in_2 & valid_in_3 = 1.
  - Any other combination: no pixel accepted and no state change.
  - No backpressure; the block is always ready.
- Position counters:
  - col and row, 0..D-1, advance once per accepted pixel.
  - col wraps at D-1 and increments row; row wraps at D-1 to 0 (next frame).
  - Frames stream back to back indefinitely.
- Storage per channel: a two-row line buffer (2*D entries) plus a 3x3 window shift register. Buffer contents are not reset.
- Window emit condition, tested for the accepted pixel at (row, col):
  - row >= 2 and col >= 2,
  - (row-2) even and (col-2) even.
  - The window is rows row-2..row, cols col-2..col of each channel.
- Arithmetic:
  - 27 products of pixel (signed data_width) x weight (signed 8).
  - Sum in a signed accumulator of data_width+13 bits.
  - Saturate to the signed data_width range [-2^(dw-1), 2^(dw-1)-1].
- Latency: pipeline stage 1 registers the products; stage 2 registers the sum. valid_out pulses high exactly 2 cycles after the accepting edge of the window's final pixel.
- Output stream: results leave in raster order of the output frame, one-cycle valid_out pulse per result.
- pxl_out holds its last value while valid_out = 0.
- Reset:
  - col = row = 0; pipeline valid bits cleared; valid_out = 0; pxl_out = 0.
  - Reset mid-frame drops in-flight results: valid_out = 0 on the cycle after reset is sampled.
  - The next accepted pixel is treated as (0,0).
- Stall (valids low) mid-frame: results are identical to an unstalled stream, only delayed.

Optional Feature:
- RELU_EN defined: after saturation, any negative result is forced to 0 before being registered into pxl_out.
- Not defined: signed saturated result is output unchanged.
- Latency is identical in both builds.

Test Plan:
- All-ones frame, D=9, default KERNEL, all three channels = 1, one pixel per cycle -> exactly 16 valid_out pulses per frame, each pxl_out = 27; pulses 2 cycles after pixels (2,2),(2,4),...,(8,8).
- Ramp: ch1 pixel = row*9+col, ch2 = ch3 = 0 -> first four outputs 90, 108, 126, 144; output row 1 starts at 252.
- Stall: deassert valid_in_2 for 5 cycles mid-frame of the ramp test -> same 16 values in the same order, no extra or missing pulses.
- Saturation: all channels 32'h7FFFFFFF -> every pxl_out = 32'h7FFFFFFF; all 32'h80000000 -> 32'h80000000.
- Negative / RELU_EN: all channels = -1 -> pxl_out = 32'hFFFFFFE5 (-27) without RELU_EN; 0 with RELU_EN.
- Reset mid-frame after 40 pixels, then restart a fresh all-ones frame -> no valid_out until pixel (2,2) of the new frame; then 16 results of 27; pxl_out = 0 between reset and the first result.
